// File: rtl/noc_credit_flit_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | noc_credit_flit_tx: credit-flow-controlled flit transmitter with staging |
// | FIFO and wormhole dest hold.                         Revision: 1.0       |
// +--------------------------------------------------------------------------+
module noc_credit_flit_tx #(
  parameter int FLIT_WIDTH        = 64,
  parameter int DEST_WIDTH        = 4,
  parameter int FLIT_BUFFER_DEPTH = 1,
  parameter int TX_FIFO_DEPTH     = 4
) (
  input  logic                                   clk_noc,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [FLIT_WIDTH-1:0]                  in_data,
  input  logic [DEST_WIDTH-1:0]                  in_dest,
  input  logic                                   in_is_tail,
  output logic [FLIT_WIDTH-1:0]                  data_out,
  output logic [DEST_WIDTH-1:0]                  dest_out,
  output logic                                   is_tail_out,
  output logic                                   send_out,
  input  logic                                   credit_in,
  output logic [$clog2(FLIT_BUFFER_DEPTH+1)-1:0] credit_count,
  output logic                                   pkt_active,
  output logic                                   credit_err
);

  localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int AW = $clog2(TX_FIFO_DEPTH);
  localparam int EW = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam logic [CW-1:0] MAX_CREDIT = CW'(FLIT_BUFFER_DEPTH);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_IN_PKT = 1'b1;

  logic [EW-1:0]         r_mem [TX_FIFO_DEPTH];
  logic [AW:0]           r_wptr;
  logic [AW:0]           r_rptr;
  logic [0:0]            r_state;
  logic [DEST_WIDTH-1:0] r_head_dest;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_issue;
  logic [EW-1:0]         w_head;
  logic [FLIT_WIDTH-1:0] w_head_data;
  logic [DEST_WIDTH-1:0] w_head_dest;
  logic                  w_head_tail;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign in_ready = !w_full;
  assign w_push   = in_valid && in_ready;

  // An empty FIFO forwards the incoming flit straight to the link register,
  // giving one-cycle latency; the entry is still written and popped in step.
  assign w_head      = w_empty ? {in_is_tail, in_dest, in_data} : r_mem[r_rptr[AW-1:0]];
  assign w_head_data = w_head[FLIT_WIDTH-1:0];
  assign w_head_dest = w_head[FLIT_WIDTH +: DEST_WIDTH];
  assign w_head_tail = w_head[EW-1];
  assign w_issue     = (!w_empty || w_push) && (credit_count != '0);

  assign pkt_active = (r_state == ST_IN_PKT);

  always_ff @(posedge clk_noc) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= {in_is_tail, in_dest, in_data};
    end
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_issue) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
      send_out    <= 1'b0;
    end else begin
      send_out <= w_issue;
      if (w_issue) begin
        data_out    <= w_head_data;
        is_tail_out <= w_head_tail;
        dest_out    <= (r_state == ST_IN_PKT) ? r_head_dest : w_head_dest;
      end
    end
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_head_dest <= '0;
    end else if (w_issue) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_head_tail) begin
            r_state     <= ST_IN_PKT;
            r_head_dest <= w_head_dest;
          end
        end
        ST_IN_PKT: begin
          if (w_head_tail) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Returning a credit to a full counter means the far end over-returned;
  // the counter saturates and the error latches until reset.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      credit_count <= MAX_CREDIT;
      credit_err   <= 1'b0;
    end else begin
      if (w_issue && !credit_in) begin
        credit_count <= credit_count - CW'(1);
      end else if (!w_issue && credit_in) begin
        if (credit_count == MAX_CREDIT) begin
          credit_err <= 1'b1;
        end else begin
          credit_count <= credit_count + CW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_credit_flit_tx.sv
`default_nettype none
// Bench for noc_credit_flit_tx: DEPTH=1 table-driven vectors plus DEPTH=4
// back-to-back packet and mid-packet reset sequences.
module tb_noc_credit_flit_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT with FLIT_BUFFER_DEPTH=1
  logic        vld1, rdy1, tail1, send1, otail1, cr1, pkt1, err1;
  logic [63:0] data1, odata1;
  logic [3:0]  dest1, odest1;
  logic [0:0]  cnt1;

  // DUT with FLIT_BUFFER_DEPTH=4, credit returned one cycle after send
  logic        vld4, rdy4, tail4, send4, otail4, cr4, pkt4, err4;
  logic [63:0] data4, odata4;
  logic [3:0]  dest4, odest4;
  logic [2:0]  cnt4;
  assign cr4 = send4;

  noc_credit_flit_tx #(.FLIT_WIDTH(64), .DEST_WIDTH(4), .FLIT_BUFFER_DEPTH(1), .TX_FIFO_DEPTH(4)) u_d1 (
    .clk_noc(clk), .rst_n(rst_n), .in_valid(vld1), .in_ready(rdy1), .in_data(data1),
    .in_dest(dest1), .in_is_tail(tail1), .data_out(odata1), .dest_out(odest1),
    .is_tail_out(otail1), .send_out(send1), .credit_in(cr1), .credit_count(cnt1),
    .pkt_active(pkt1), .credit_err(err1));

  noc_credit_flit_tx #(.FLIT_WIDTH(64), .DEST_WIDTH(4), .FLIT_BUFFER_DEPTH(4), .TX_FIFO_DEPTH(4)) u_d4 (
    .clk_noc(clk), .rst_n(rst_n), .in_valid(vld4), .in_ready(rdy4), .in_data(data4),
    .in_dest(dest4), .in_is_tail(tail4), .data_out(odata4), .dest_out(odest4),
    .is_tail_out(otail4), .send_out(send4), .credit_in(cr4), .credit_count(cnt4),
    .pkt_active(pkt4), .credit_err(err4));

  typedef struct {
    logic        vld;
    logic [63:0] data;
    logic [3:0]  dest;
    logic        tail;
    logic        cr;
    logic        e_send;
    logic [63:0] e_data;
    logic [3:0]  e_dest;
    logic        e_tail;
    logic        e_cnt;
    logic        e_pkt;
    logic        e_rdy;
    logic        e_err;
  } vec_t;

  vec_t vecs [19];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic vld, input logic [63:0] d, input logic [3:0] ds,
                              input logic tl, input logic cr, input logic es, input logic [63:0] ed,
                              input logic [3:0] eds, input logic et, input logic ec, input logic ep,
                              input logic er, input logic ee);
    vec_t v;
    v.vld = vld; v.data = d; v.dest = ds; v.tail = tl; v.cr = cr;
    v.e_send = es; v.e_data = ed; v.e_dest = eds; v.e_tail = et;
    v.e_cnt = ec; v.e_pkt = ep; v.e_rdy = er; v.e_err = ee;
    return v;
  endfunction

  initial begin
    //                vld data    dst  tl cr | snd data    dst  tl cnt pkt rdy err
    vecs[0]  = mk(1, 64'hA1, 4'h5, 0, 0,   1, 64'hA1, 4'h5, 0, 0, 1, 1, 0);
    vecs[1]  = mk(1, 64'hA2, 4'h9, 1, 0,   0, 64'hA1, 4'h5, 0, 0, 1, 1, 0);
    vecs[2]  = mk(0, 64'h0,  4'h0, 0, 0,   0, 64'hA1, 4'h5, 0, 0, 1, 1, 0);
    vecs[3]  = mk(0, 64'h0,  4'h0, 0, 1,   0, 64'hA1, 4'h5, 0, 1, 1, 1, 0);
    vecs[4]  = mk(0, 64'h0,  4'h0, 0, 0,   1, 64'hA2, 4'h5, 1, 0, 0, 1, 0);
    vecs[5]  = mk(0, 64'h0,  4'h0, 0, 1,   0, 64'hA2, 4'h5, 1, 1, 0, 1, 0);
    vecs[6]  = mk(0, 64'h0,  4'h0, 0, 1,   0, 64'hA2, 4'h5, 1, 1, 0, 1, 1);
    vecs[7]  = mk(1, 64'hB1, 4'h3, 1, 1,   1, 64'hB1, 4'h3, 1, 1, 0, 1, 1);
    vecs[8]  = mk(1, 64'hC0, 4'h7, 0, 0,   1, 64'hC0, 4'h7, 0, 0, 1, 1, 1);
    vecs[9]  = mk(1, 64'hC1, 4'hF, 0, 0,   0, 64'hC0, 4'h7, 0, 0, 1, 1, 1);
    vecs[10] = mk(1, 64'hC2, 4'hF, 0, 0,   0, 64'hC0, 4'h7, 0, 0, 1, 1, 1);
    vecs[11] = mk(1, 64'hC3, 4'hF, 0, 0,   0, 64'hC0, 4'h7, 0, 0, 1, 1, 1);
    vecs[12] = mk(1, 64'hC4, 4'hF, 0, 0,   0, 64'hC0, 4'h7, 0, 0, 1, 0, 1);
    vecs[13] = mk(1, 64'hC5, 4'hF, 1, 0,   0, 64'hC0, 4'h7, 0, 0, 1, 0, 1);
    vecs[14] = mk(1, 64'hC5, 4'hF, 1, 1,   0, 64'hC0, 4'h7, 0, 1, 1, 0, 1);
    vecs[15] = mk(1, 64'hC5, 4'hF, 1, 0,   1, 64'hC1, 4'h7, 0, 0, 1, 1, 1);
    vecs[16] = mk(1, 64'hC5, 4'hF, 1, 0,   0, 64'hC1, 4'h7, 0, 0, 1, 0, 1);
    vecs[17] = mk(0, 64'h0,  4'h0, 0, 1,   0, 64'hC1, 4'h7, 0, 1, 1, 0, 1);
    vecs[18] = mk(0, 64'h0,  4'h0, 0, 0,   1, 64'hC2, 4'h7, 0, 0, 1, 1, 1);

    vld1 = 0; data1 = '0; dest1 = '0; tail1 = 0; cr1 = 0;
    vld4 = 0; data4 = '0; dest4 = '0; tail4 = 0;

    // Reset state
    step(); step();
    chk("rst_send", send1, 0);
    chk("rst_data", odata1, 0);
    chk("rst_dest", odest1, 0);
    chk("rst_tail", otail1, 0);
    chk("rst_cnt1", cnt1, 1);
    chk("rst_cnt4", cnt4, 4);
    chk("rst_pkt", pkt1, 0);
    chk("rst_err", err1, 0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", rdy1, 1);

    // DEPTH=4: 8-flit packet back to back, credits returned after each send
    for (int i = 0; i < 12; i++) begin
      vld4  = (i < 8);
      data4 = 64'h3000 + 64'(i);
      dest4 = (i == 0) ? 4'h2 : 4'hF;
      tail4 = (i == 7);
      step();
      chk("t3_send", send4, (i < 8));
      if (i < 8) begin
        chk("t3_data", odata4, 64'h3000 + 64'(i));
        chk("t3_dest", odest4, 4'h2);
        chk("t3_tail", otail4, (i == 7));
      end
      chk("t3_cnt_ge3", (cnt4 >= 3'd3), 1);
      chk("t3_pkt", pkt4, (i < 7));
      chk("t3_err", err4, 0);
    end
    vld4 = 0;

    // DEPTH=1 vector table
    for (int i = 0; i < 19; i++) begin
      vld1 = vecs[i].vld; data1 = vecs[i].data; dest1 = vecs[i].dest;
      tail1 = vecs[i].tail; cr1 = vecs[i].cr;
      step();
      chk($sformatf("v%0d_send", i), send1, vecs[i].e_send);
      chk($sformatf("v%0d_data", i), odata1, vecs[i].e_data);
      chk($sformatf("v%0d_dest", i), odest1, vecs[i].e_dest);
      chk($sformatf("v%0d_tail", i), otail1, vecs[i].e_tail);
      chk($sformatf("v%0d_cnt", i), cnt1, vecs[i].e_cnt);
      chk($sformatf("v%0d_pkt", i), pkt1, vecs[i].e_pkt);
      chk($sformatf("v%0d_rdy", i), rdy1, vecs[i].e_rdy);
      chk($sformatf("v%0d_err", i), err1, vecs[i].e_err);
    end
    vld1 = 0; cr1 = 0;

    // Asynchronous reset mid-packet: outputs clear before any clock edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_send", send1, 0);
    chk("t6_data", odata1, 0);
    chk("t6_dest", odest1, 0);
    chk("t6_tail", otail1, 0);
    chk("t6_cnt", cnt1, 1);
    chk("t6_pkt", pkt1, 0);
    chk("t6_err", err1, 0);
    chk("t6_cnt4", cnt4, 4);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_ready", rdy1, 1);
    chk("t6_send_after", send1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
